seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed LED display bus (AN/cathodes),
// captures each digit's segment byte once it has been stable long enough, and
// decodes it to a hex nibble. A frame pulse marks every digit refreshed.
// Optional build macro: SEG_DEC_SYNC_EN adds a 2-flop input synchronizer.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   AN,
    input  logic                    CA,
    input  logic                    CB,
    input  logic                    CC,
    input  logic                    CD,
    input  logic                    CE,
    input  logic                    CF,
    input  logic                    CG,
    input  logic                    DP,
    output logic [NUM_DIGITS*8-1:0] digit_raw,
    output logic [NUM_DIGITS*4-1:0] digit_hex,
    output logic [NUM_DIGITS-1:0]   hex_valid,
    output logic                    frame_valid,
    output logic                    scan_active,
    output logic                    anode_err
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StBlank, StSettle, StHold} state_e;

    // Segment byte -> {valid, nibble}; DP is not part of the pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [7:0]            cat_raw;
    logic [NUM_DIGITS-1:0] an_s;
    logic [7:0]            cat_s;

    assign cat_raw = {DP, CG, CF, CE, CD, CC, CB, CA};

`ifdef SEG_DEC_SYNC_EN
    logic [NUM_DIGITS-1:0] an_meta_q, an_sync_q;
    logic [7:0]            cat_meta_q, cat_sync_q;

    // Two-flop synchronizer; idles at all ones so reset looks like a blank bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_meta_q  <= '1;
            an_sync_q  <= '1;
            cat_meta_q <= '1;
            cat_sync_q <= '1;
        end else begin
            an_meta_q  <= AN;
            an_sync_q  <= an_meta_q;
            cat_meta_q <= cat_raw;
            cat_sync_q <= cat_meta_q;
        end
    end

    assign an_s  = an_sync_q;
    assign cat_s = cat_sync_q;
`else
    assign an_s  = AN;
    assign cat_s = cat_raw;
`endif

    // Anode classification: idle / exactly one low / several low.
    logic [NUM_DIGITS-1:0] an_low;
    logic                  is_one;
    logic                  is_multi;
    logic [IdxW-1:0]       one_idx;

    assign an_low = ~an_s;

    // Power-of-two test on the low bits, plus the low bit's index.
    always_comb begin
        is_one   = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
        is_multi = (an_low != '0) && !is_one;
        one_idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) one_idx = IdxW'(i);
        end
    end

    state_e          state_q, state_d;
    logic [IdxW-1:0] cur_idx_q, cur_idx_d;
    logic [7:0]      settle_cnt_q, settle_cnt_d;
    logic [7:0]      ref_byte_q, ref_byte_d;

    logic            cap;
    logic [IdxW-1:0] cap_idx;
    logic [7:0]      cap_byte;
    logic            start;

    // Capture FSM next state; a fresh anode (re)starts the settle window.
    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        settle_cnt_d = settle_cnt_q;
        ref_byte_d   = ref_byte_q;
        cap          = 1'b0;
        cap_idx      = cur_idx_q;
        cap_byte     = ref_byte_q;
        start        = 1'b0;

        if (!is_one) begin
            state_d      = StBlank;
            settle_cnt_d = '0;
        end else begin
            case (state_q)
                StBlank: start = 1'b1;
                StSettle: begin
                    if (one_idx == cur_idx_q && cat_s == ref_byte_q) begin
                        if (int'(settle_cnt_q) + 1 >= int'(SETTLE_CYCLES)) begin
                            cap          = 1'b1;
                            state_d      = StHold;
                            settle_cnt_d = '0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + 8'd1;
                        end
                    end else begin
                        start = 1'b1;
                    end
                end
                StHold: begin
                    // Cathode changes under the held anode are ignored.
                    if (one_idx != cur_idx_q) start = 1'b1;
                end
                default: state_d = StBlank;
            endcase

            if (start) begin
                state_d      = StSettle;
                cur_idx_d    = one_idx;
                ref_byte_d   = cat_s;
                settle_cnt_d = 8'd1;
                cap_idx      = one_idx;
                cap_byte     = cat_s;
                // A one-cycle settle window captures on the first sighting.
                if (SETTLE_CYCLES <= 1) begin
                    cap          = 1'b1;
                    state_d      = StHold;
                    settle_cnt_d = '0;
                end
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBlank;
            cur_idx_q    <= '0;
            settle_cnt_q <= '0;
            ref_byte_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            settle_cnt_q <= settle_cnt_d;
            ref_byte_q   <= ref_byte_d;
        end
    end

    logic [NUM_DIGITS*8-1:0] digit_raw_q, digit_raw_d;
    logic [NUM_DIGITS*4-1:0] digit_hex_q, digit_hex_d;
    logic [NUM_DIGITS-1:0]   hex_valid_q, hex_valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic                    any_cap_q, any_cap_d;
    logic                    anode_err_q, anode_err_d;
    logic [4:0]              dec;

    assign dec = hex_decode(cap_byte[6:0]);

    // Digit storage, frame tracking, timeout and error next state.
    always_comb begin
        digit_raw_d = digit_raw_q;
        digit_hex_d = digit_hex_q;
        hex_valid_d = hex_valid_q;
        // A full seen vector is consumed by this cycle's frame pulse.
        seen_d      = (&seen_q) ? '0 : seen_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && cap_idx == IdxW'(i)) begin
                digit_raw_d[i*8 +: 8] = cap_byte;
                digit_hex_d[i*4 +: 4] = dec[3:0];
                hex_valid_d[i]        = dec[4];
                seen_d[i]             = 1'b1;
            end
        end
        frame_valid_d = &seen_q;
        if (cap) begin
            tmo_d = '0;
        end else if (tmo_q >= TmoMax) begin
            tmo_d = TmoMax;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
        any_cap_d   = any_cap_q | cap;
        anode_err_d = anode_err_q | is_multi;
    end

    // Output-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_raw_q   <= '1;
            digit_hex_q   <= '0;
            hex_valid_q   <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            tmo_q         <= '0;
            any_cap_q     <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            digit_raw_q   <= digit_raw_d;
            digit_hex_q   <= digit_hex_d;
            hex_valid_q   <= hex_valid_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            tmo_q         <= tmo_d;
            any_cap_q     <= any_cap_d;
            anode_err_q   <= anode_err_d;
        end
    end

    assign digit_raw   = digit_raw_q;
    assign digit_hex   = digit_hex_q;
    assign hex_valid   = hex_valid_q;
    assign frame_valid = frame_valid_q;
    assign scan_active = any_cap_q && (tmo_q < TmoMax);
    assign anode_err   = anode_err_q;

endmodule
